// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives instruction memory and
// registers the fetched word and its PC into the IF/ID boundary. A redirect
// (register- or memory-sourced jump target) reloads the PC and emits
// FLUSH_CYCLES + 1 bubbles before the target instruction appears.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
    parameter int          WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic [WIDTH-1:0] target_rs,
    input  logic [WIDTH-1:0] target_mem,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] pc_if,
    output logic [WIDTH-1:0] inst_if,
    output logic             valid_if,
`ifdef FETCH_PERF_EN
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_bubbles,
`endif
    output logic             busy
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_if_q, pc_if_d;
    logic [WIDTH-1:0] inst_if_q, inst_if_d;
    logic             valid_if_q, valid_if_d;

    logic             redirect;
    logic             hold;

    // Only 01 and 10 redirect; 11 is reserved and falls through as sequential.
    assign redirect = (pc_sel == 2'b01) || (pc_sel == 2'b10);
    assign hold     = stall && !redirect;

    // Next-state selection: redirect > stall > flush countdown > sequential fetch.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        pc_if_d    = pc_if_q;
        inst_if_d  = inst_if_q;
        valid_if_d = valid_if_q;

        if (redirect) begin
            pc_d       = (pc_sel == 2'b01) ? target_rs : target_mem;
            pc_if_d    = '0;
            inst_if_d  = '0;
            valid_if_d = 1'b0;
            if (FLUSH_CYCLES > 0) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_INIT;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (stall) begin
            // Everything holds; defaults already cover it.
        end else if (state_q == FLUSH) begin
            pc_if_d    = '0;
            inst_if_d  = '0;
            valid_if_d = 1'b0;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            pc_if_d    = pc_q;
            inst_if_d  = imem_data;
            valid_if_d = 1'b1;
            pc_d       = pc_q + 1'b1;
        end
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            pc_if_q    <= '0;
            inst_if_q  <= '0;
            valid_if_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            pc_if_q    <= pc_if_d;
            inst_if_q  <= inst_if_d;
            valid_if_q <= valid_if_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_if     = pc_if_q;
    assign inst_if   = inst_if_q;
    assign valid_if  = valid_if_q;
    assign busy      = (state_q == FLUSH);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    // Count edges that register a real instruction or a non-stall bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else if (!hold) begin
            if (valid_if_d) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`else
    // No performance counters in this build; hold is only a helper here.
    logic unused_hold;
    assign unused_hold = hold;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Two instances share stimulus:
//   a: RESET_PC = 0,          FLUSH_CYCLES = 2
//   b: RESET_PC = 0xFFFFFFFF, FLUSH_CYCLES = 0
// Each is compared every cycle against a bubble-counting reference model,
// plus directed expectations for the documented scenarios.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] target_rs;
    logic [31:0] target_mem;

    logic [31:0] a_addr, a_data, a_pc, a_inst;
    logic        a_valid, a_busy;
    logic [31:0] b_addr, b_data, b_pc, b_inst;
    logic        b_valid, b_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] a_pf, a_pb, b_pf, b_pb;
`endif

    // Instruction memory: word at address A is A + 0x100.
    assign a_data = a_addr + 32'h100;
    assign b_data = b_addr + 32'h100;

    always #5 clock = ~clock;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut_a (
        .clock(clock), .reset(reset), .stall(stall), .pc_sel(pc_sel),
        .target_rs(target_rs), .target_mem(target_mem),
        .imem_addr(a_addr), .imem_data(a_data),
        .pc_if(a_pc), .inst_if(a_inst), .valid_if(a_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched(a_pf), .perf_bubbles(a_pb),
`endif
        .busy(a_busy)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFF), .FLUSH_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .stall(stall), .pc_sel(pc_sel),
        .target_rs(target_rs), .target_mem(target_mem),
        .imem_addr(b_addr), .imem_data(b_data),
        .pc_if(b_pc), .inst_if(b_inst), .valid_if(b_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched(b_pf), .perf_bubbles(b_pb),
`endif
        .busy(b_busy)
    );

    // Reference model: PC plus number of bubbles still owed.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_if;
        logic [31:0] inst;
        logic        valid;
        int          left;
        logic [31:0] fetched;
        logic [31:0] bubbles;
    } model_t;

    model_t      m [2];
    logic [31:0] rst_pc [2] = '{32'h0, 32'hFFFF_FFFF};
    int          flush_n [2] = '{2, 0};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m[k].pc      = rst_pc[k];
        m[k].pc_if   = '0;
        m[k].inst    = '0;
        m[k].valid   = 1'b0;
        m[k].left    = 0;
        m[k].fetched = '0;
        m[k].bubbles = '0;
    endtask

    task automatic model_bubble(input int k);
        m[k].pc_if   = '0;
        m[k].inst    = '0;
        m[k].valid   = 1'b0;
        m[k].bubbles = m[k].bubbles + 1;
    endtask

    task automatic model_edge(input int k);
        if (pc_sel == 2'd1 || pc_sel == 2'd2) begin
            m[k].pc   = (pc_sel == 2'd1) ? target_rs : target_mem;
            m[k].left = flush_n[k];
            model_bubble(k);
        end else if (stall) begin
            // frozen
        end else if (m[k].left > 0) begin
            m[k].left = m[k].left - 1;
            model_bubble(k);
        end else begin
            m[k].pc_if   = m[k].pc;
            m[k].inst    = m[k].pc + 32'h100;
            m[k].valid   = 1'b1;
            m[k].pc      = m[k].pc + 32'd1;
            m[k].fetched = m[k].fetched + 1;
        end
    endtask

    task automatic compare_all();
        check("a.addr",  a_addr,  m[0].pc);
        check("a.pc_if", a_pc,    m[0].pc_if);
        check("a.inst",  a_inst,  m[0].inst);
        check("a.valid", 32'(a_valid), 32'(m[0].valid));
        check("a.busy",  32'(a_busy),  32'(m[0].left > 0));
        check("b.addr",  b_addr,  m[1].pc);
        check("b.pc_if", b_pc,    m[1].pc_if);
        check("b.inst",  b_inst,  m[1].inst);
        check("b.valid", 32'(b_valid), 32'(m[1].valid));
        check("b.busy",  32'(b_busy),  32'(m[1].left > 0));
`ifdef FETCH_PERF_EN
        check("a.perf_fetched", a_pf, m[0].fetched);
        check("a.perf_bubbles", a_pb, m[0].bubbles);
        check("b.perf_fetched", b_pf, m[1].fetched);
        check("b.perf_bubbles", b_pb, m[1].bubbles);
`endif
    endtask

    // One clock edge: model follows the held inputs, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        if (!reset) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic s, input logic [1:0] sel,
                          input logic [31:0] trs, input logic [31:0] tmem);
        stall      = s;
        pc_sel     = sel;
        target_rs  = trs;
        target_mem = tmem;
    endtask

    // Asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic pulse_reset();
        #1;
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check("rst.valid", 32'(a_valid), 32'd0);
        check("rst.busy",  32'(a_busy),  32'd0);
        check("rst.pc_if", a_pc,   32'd0);
        check("rst.inst",  a_inst, 32'd0);
        check("rst.b_addr", b_addr, 32'hFFFF_FFFF);
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 2'b00, '0, '0);
        model_reset(0);
        model_reset(1);
        #12;
        compare_all();
        reset = 1'b0;

        // Sequential fetch from RESET_PC; b wraps 0xFFFFFFFF -> 0.
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1.pc_if", a_pc, 32'(i));
            check("t1.inst",  a_inst, 32'h100 + 32'(i));
            check("t1.valid", 32'(a_valid), 32'd1);
            if (i == 0) check("t5.b_first", b_pc, 32'hFFFF_FFFF);
            if (i == 1) check("t5.b_wrap",  b_pc, 32'h0);
        end

        // Redirect to 0x40: three bubbles, busy for two, then 0x40 valid.
        set_in(1'b0, 2'b01, 32'h40, 32'h1234);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0);
        check("t3.e0.valid", 32'(a_valid), 32'd0);
        check("t3.e0.busy",  32'(a_busy),  32'd1);
        step();
        check("t3.e1.valid", 32'(a_valid), 32'd0);
        check("t3.e1.busy",  32'(a_busy),  32'd1);
        step();
        check("t3.e2.valid", 32'(a_valid), 32'd0);
        check("t3.e2.busy",  32'(a_busy),  32'd0);
        step();
        check("t3.pc_if", a_pc, 32'h40);
        check("t3.valid", 32'(a_valid), 32'd1);
        step();
        step();
        step();
`ifdef FETCH_PERF_EN
        check("t6.sum",     a_pf + a_pb, 32'd10);
        check("t6.bubbles", a_pb, 32'd3);
`endif

        // Stall for 3 cycles at pc = 5.
        pulse_reset();
        for (int i = 0; i < 5; i++) step();
        check("t2.addr", a_addr, 32'd5);
        set_in(1'b1, 2'b00, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2.hold.pc_if", a_pc, 32'd4);
            check("t2.hold.valid", 32'(a_valid), 32'd1);
        end
        set_in(1'b0, 2'b00, '0, '0);
        step();
        check("t2.release", a_pc, 32'd5);

        // Redirect to 0x40, then to 0x80 in the first flush cycle.
        set_in(1'b0, 2'b01, 32'h40, 32'h0);
        step();
        set_in(1'b0, 2'b10, 32'h0, 32'h80);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("t4.bubble", 32'(a_valid), 32'd0);
            check("t4.no40", 32'(a_valid && a_pc == 32'h40), 32'd0);
            step();
        end
        check("t4.pc_if", a_pc, 32'h80);
        check("t4.valid", 32'(a_valid), 32'd1);

        // Redirect together with stall: redirect wins.
        set_in(1'b1, 2'b01, 32'h200, 32'h0);
        step();
        check("t4.rs_stall.addr",  a_addr, 32'h200);
        check("t4.rs_stall.valid", 32'(a_valid), 32'd0);
        check("t4.rs_stall.busy",  32'(a_busy), 32'd1);

        // Reset asserted in the middle of the flush.
        set_in(1'b0, 2'b00, '0, '0);
        pulse_reset();
        check("t5.mid.addr", a_addr, 32'h0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] sel;
            sel = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 2))
                                               : (($urandom_range(0, 9) == 0) ? 2'b11 : 2'b00);
            set_in($urandom_range(0, 99) < 20, sel, $urandom, $urandom);
            if ($urandom_range(0, 99) < 2) pulse_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
